// File: rtl/car_sequencer_if.sv
// Handshake bundle between the instruction decoder/control side and the CAR sequencer.
// master = decoder/control side, slave = sequencer.
interface car_sequencer_if #(
  parameter int CAR_BITS = 6
);
  logic [CAR_BITS-1:0] car_decoded;
  logic                iw_valid;
  logic                seq_end;
  logic                stall;
  logic                int_req;
  logic [CAR_BITS-1:0] car;
  logic                fetching;
  logic                int_ack;
  logic                illegal;

  modport master (
    output car_decoded, iw_valid, seq_end, stall, int_req,
    input  car, fetching, int_ack, illegal
  );

  modport slave (
    input  car_decoded, iw_valid, seq_end, stall, int_req,
    output car, fetching, int_ack, illegal
  );
endinterface

// File: rtl/car_sequencer.sv
// Microcode control-address sequencer: FETCH -> EXEC/INT step sequences, interrupt entry, overflow trap.
// Latency: iw_valid to decoded car in 1 cycle; one micro-step per unstalled cycle.
// Backpressure: stall freezes car and state and suppresses int_ack/illegal pulses.
module car_sequencer #(
  parameter int                  CAR_BITS  = 6,
  parameter logic [CAR_BITS-1:0] CAR_FETCH = '0,
  parameter logic [CAR_BITS-1:0] CAR_INT0  = 6'd56
) (
  input  logic          MCLK,
  input  logic          reset,
  car_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_INT   = 2'd2
  } state_t;

  state_t              r_state;
  logic [CAR_BITS-1:0] r_car;
  logic                r_int_ack;
  logic                r_illegal;

  logic                w_car_max;
  logic                w_decode_undef;

  assign w_car_max      = &r_car;
  assign w_decode_undef = (bus.car_decoded == CAR_FETCH);

  assign bus.car      = r_car;
  assign bus.fetching = (r_state == ST_FETCH);
  assign bus.int_ack  = r_int_ack;
  assign bus.illegal  = r_illegal;

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_car     <= CAR_FETCH;
      r_int_ack <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      // Pulses default low every edge, including stalled ones.
      r_int_ack <= 1'b0;
      r_illegal <= 1'b0;
      if (!bus.stall) begin
        case (r_state)
          ST_FETCH: begin
            if (bus.int_req) begin
              r_car     <= CAR_INT0;
              r_state   <= ST_INT;
              r_int_ack <= 1'b1;
            end else if (bus.iw_valid) begin
              if (w_decode_undef) begin
                r_car     <= CAR_FETCH;
                r_illegal <= 1'b1;
              end else begin
                r_car   <= bus.car_decoded;
                r_state <= ST_EXEC;
              end
            end
          end
          ST_EXEC, ST_INT: begin
            if (bus.seq_end) begin
              r_car   <= CAR_FETCH;
              r_state <= ST_FETCH;
            end else if (w_car_max) begin
              // Running off the top of the ROM is a microcode fault, not a wrap.
              r_car     <= CAR_FETCH;
              r_state   <= ST_FETCH;
              r_illegal <= 1'b1;
            end else begin
              r_car <= r_car + 1'b1;
            end
          end
          default: begin
            r_car   <= CAR_FETCH;
            r_state <= ST_FETCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_car_sequencer.sv
// Self-checking bench for car_sequencer: directed scenarios plus randomized run against a reference model.
module tb_car_sequencer;
  localparam int CB     = 6;
  localparam int C_FET  = 0;
  localparam int C_INT0 = 56;
  localparam int C_MAX  = 63;

  logic MCLK;
  logic reset;
  int   checks;
  int   errors;

  car_sequencer_if #(.CAR_BITS(CB)) bus ();

  car_sequencer #(
    .CAR_BITS (CB),
    .CAR_FETCH(6'd0),
    .CAR_INT0 (6'd56)
  ) dut (
    .MCLK (MCLK),
    .reset(reset),
    .bus  (bus)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // Reference model: "in a sequence" flag plus current control address.
  int m_car;
  bit m_in_seq;
  bit m_ack;
  bit m_ill;

  task automatic model_edge();
    m_ack = 1'b0;
    m_ill = 1'b0;
    if (bus.stall) return;
    if (!m_in_seq) begin
      if (bus.int_req) begin
        m_car = C_INT0; m_in_seq = 1'b1; m_ack = 1'b1;
      end else if (bus.iw_valid) begin
        if (int'(bus.car_decoded) == C_FET) m_ill = 1'b1;
        else begin m_car = int'(bus.car_decoded); m_in_seq = 1'b1; end
      end
    end else begin
      if (bus.seq_end) begin
        m_car = C_FET; m_in_seq = 1'b0;
      end else if (m_car == C_MAX) begin
        m_car = C_FET; m_in_seq = 1'b0; m_ill = 1'b1;
      end else begin
        m_car = m_car + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.car_decoded = '0;
    bus.iw_valid    = 1'b0;
    bus.seq_end     = 1'b0;
    bus.stall       = 1'b0;
    bus.int_req     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    @(negedge MCLK);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #3;
    checks++; if (bus.car !== 6'd0) begin errors++; $display("FAIL reset_car got %0d want 0", bus.car); end
    checks++; if (bus.fetching !== 1'b1) begin errors++; $display("FAIL reset_fetching got %b want 1", bus.fetching); end
    checks++; if (bus.int_ack !== 1'b0) begin errors++; $display("FAIL reset_int_ack got %b want 0", bus.int_ack); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", bus.illegal); end
    @(negedge MCLK);
    reset = 1'b0;
    tick();
    checks++; if (bus.car !== 6'd0 || bus.fetching !== 1'b1) begin errors++; $display("FAIL reset_idle car=%0d fetching=%b want 0/1", bus.car, bus.fetching); end
  endtask

  task automatic test_sequence();
    bus.iw_valid = 1'b1; bus.car_decoded = 6'd8;
    tick();
    checks++; if (bus.car !== 6'd8 || bus.fetching !== 1'b0) begin errors++; $display("FAIL seq_step1 car=%0d fetching=%b want 8/0", bus.car, bus.fetching); end
    bus.iw_valid = 1'b0; bus.car_decoded = 6'd20;
    tick();
    checks++; if (bus.car !== 6'd9 || bus.fetching !== 1'b0) begin errors++; $display("FAIL seq_step2 car=%0d fetching=%b want 9/0", bus.car, bus.fetching); end
    tick();
    checks++; if (bus.car !== 6'd10 || bus.fetching !== 1'b0) begin errors++; $display("FAIL seq_step3 car=%0d fetching=%b want 10/0", bus.car, bus.fetching); end
    bus.seq_end = 1'b1;
    tick();
    checks++; if (bus.car !== 6'd0 || bus.fetching !== 1'b1) begin errors++; $display("FAIL seq_return car=%0d fetching=%b want 0/1", bus.car, bus.fetching); end
    // seq_end must not matter in FETCH
    tick();
    checks++; if (bus.car !== 6'd0 || bus.fetching !== 1'b1 || bus.illegal !== 1'b0) begin errors++; $display("FAIL seq_fetch_hold car=%0d fetching=%b ill=%b want 0/1/0", bus.car, bus.fetching, bus.illegal); end
    idle_inputs();
  endtask

  task automatic test_interrupt();
    bus.int_req = 1'b1; bus.iw_valid = 1'b1; bus.car_decoded = 6'd8;
    tick();
    checks++; if (bus.car !== 6'd56) begin errors++; $display("FAIL int_car got %0d want 56", bus.car); end
    checks++; if (bus.int_ack !== 1'b1 || bus.fetching !== 1'b0 || bus.illegal !== 1'b0) begin errors++; $display("FAIL int_entry ack=%b fetching=%b ill=%b want 1/0/0", bus.int_ack, bus.fetching, bus.illegal); end
    // int_req still high but ignored outside FETCH
    tick();
    checks++; if (bus.car !== 6'd57 || bus.int_ack !== 1'b0) begin errors++; $display("FAIL int_step2 car=%0d ack=%b want 57/0", bus.car, bus.int_ack); end
    bus.int_req = 1'b0; bus.iw_valid = 1'b0; bus.seq_end = 1'b1;
    tick();
    checks++; if (bus.car !== 6'd0 || bus.fetching !== 1'b1 || bus.int_ack !== 1'b0) begin errors++; $display("FAIL int_return car=%0d fetching=%b ack=%b want 0/1/0", bus.car, bus.fetching, bus.int_ack); end
    idle_inputs();
  endtask

  task automatic test_illegal();
    bus.iw_valid = 1'b1; bus.car_decoded = 6'd0;
    tick();
    checks++; if (bus.illegal !== 1'b1 || bus.car !== 6'd0 || bus.fetching !== 1'b1 || bus.int_ack !== 1'b0) begin errors++; $display("FAIL illegal_pulse ill=%b car=%0d fetching=%b ack=%b want 1/0/1/0", bus.illegal, bus.car, bus.fetching, bus.int_ack); end
    bus.iw_valid = 1'b0;
    tick();
    checks++; if (bus.illegal !== 1'b0 || bus.car !== 6'd0) begin errors++; $display("FAIL illegal_clear ill=%b car=%0d want 0/0", bus.illegal, bus.car); end
    idle_inputs();
  endtask

  task automatic test_stall();
    bus.stall = 1'b1; bus.int_req = 1'b1;
    tick();
    checks++; if (bus.int_ack !== 1'b0 || bus.car !== 6'd0 || bus.fetching !== 1'b1) begin errors++; $display("FAIL stall_fetch ack=%b car=%0d fetching=%b want 0/0/1", bus.int_ack, bus.car, bus.fetching); end
    idle_inputs();
    bus.iw_valid = 1'b1; bus.car_decoded = 6'd9;
    tick();
    checks++; if (bus.car !== 6'd9) begin errors++; $display("FAIL stall_load car got %0d want 9", bus.car); end
    bus.iw_valid = 1'b0; bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.seq_end = i[0];
      tick();
      checks++; if (bus.car !== 6'd9 || bus.fetching !== 1'b0 || bus.illegal !== 1'b0) begin errors++; $display("FAIL stall_hold%0d car=%0d fetching=%b ill=%b want 9/0/0", i, bus.car, bus.fetching, bus.illegal); end
    end
    bus.stall = 1'b0; bus.seq_end = 1'b0;
    tick();
    checks++; if (bus.car !== 6'd10) begin errors++; $display("FAIL stall_release car got %0d want 10", bus.car); end
    bus.seq_end = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_overflow();
    bus.iw_valid = 1'b1; bus.car_decoded = 6'd62;
    tick();
    checks++; if (bus.car !== 6'd62) begin errors++; $display("FAIL ovf_load car got %0d want 62", bus.car); end
    bus.iw_valid = 1'b0;
    tick();
    checks++; if (bus.car !== 6'd63 || bus.illegal !== 1'b0) begin errors++; $display("FAIL ovf_top car=%0d ill=%b want 63/0", bus.car, bus.illegal); end
    tick();
    checks++; if (bus.car !== 6'd0 || bus.illegal !== 1'b1 || bus.fetching !== 1'b1) begin errors++; $display("FAIL ovf_trap car=%0d ill=%b fetching=%b want 0/1/1", bus.car, bus.illegal, bus.fetching); end
    tick();
    checks++; if (bus.illegal !== 1'b0 || bus.fetching !== 1'b1) begin errors++; $display("FAIL ovf_after ill=%b fetching=%b want 0/1", bus.illegal, bus.fetching); end
  endtask

  task automatic test_async_reset();
    bus.iw_valid = 1'b1; bus.car_decoded = 6'd8;
    tick();
    bus.iw_valid = 1'b0;
    tick();
    tick();
    checks++; if (bus.car !== 6'd10) begin errors++; $display("FAIL areset_setup car got %0d want 10", bus.car); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.car !== 6'd0 || bus.fetching !== 1'b1) begin errors++; $display("FAIL areset_now car=%0d fetching=%b want 0/1", bus.car, bus.fetching); end
    @(negedge MCLK);
    reset = 1'b0;
    tick();
    checks++; if (bus.int_ack !== 1'b0 || bus.illegal !== 1'b0 || bus.car !== 6'd0) begin errors++; $display("FAIL areset_release ack=%b ill=%b car=%0d want 0/0/0", bus.int_ack, bus.illegal, bus.car); end
    // a live illegal pulse must be cleared by reset
    bus.iw_valid = 1'b1; bus.car_decoded = 6'd0;
    tick();
    bus.iw_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL areset_pulse ill got %b want 0", bus.illegal); end
    @(negedge MCLK);
    reset = 1'b0;
    tick();
    checks++; if (bus.illegal !== 1'b0 || bus.int_ack !== 1'b0 || bus.fetching !== 1'b1) begin errors++; $display("FAIL areset_pulse_after ill=%b ack=%b fetching=%b want 0/0/1", bus.illegal, bus.int_ack, bus.fetching); end
  endtask

  task automatic test_random();
    int sel;
    do_reset();
    m_car = C_FET; m_in_seq = 1'b0; m_ack = 1'b0; m_ill = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      bus.stall    = ($urandom_range(0, 7) == 0);
      bus.int_req  = ($urandom_range(0, 3) == 0);
      bus.iw_valid = $urandom_range(0, 1);
      bus.seq_end  = ($urandom_range(0, 5) == 0);
      sel = $urandom_range(0, 7);
      if (sel == 0)      bus.car_decoded = 6'd0;
      else if (sel == 1) bus.car_decoded = 6'd62;
      else if (sel == 2) bus.car_decoded = 6'd63;
      else               bus.car_decoded = 6'($urandom_range(0, 63));
      model_edge();
      tick();
      checks++; if (int'(bus.car) != m_car) begin errors++; $display("FAIL rnd_car cyc %0d got %0d want %0d", n, bus.car, m_car); end
      checks++; if (bus.fetching !== !m_in_seq) begin errors++; $display("FAIL rnd_fetching cyc %0d got %b want %b", n, bus.fetching, !m_in_seq); end
      checks++; if (bus.int_ack !== m_ack) begin errors++; $display("FAIL rnd_int_ack cyc %0d got %b want %b", n, bus.int_ack, m_ack); end
      checks++; if (bus.illegal !== m_ill) begin errors++; $display("FAIL rnd_illegal cyc %0d got %b want %b", n, bus.illegal, m_ill); end
      checks++; if (bus.int_ack === 1'b1 && bus.illegal === 1'b1) begin errors++; $display("FAIL rnd_exclusive cyc %0d ack=%b ill=%b want not both 1", n, bus.int_ack, bus.illegal); end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_sequence();
    test_interrupt();
    test_illegal();
    test_stall();
    test_overflow();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
